// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the 5-stage CPU sequencing logic:
// FSM state encoding, RAM-port owner codes and register-id width.
package cpu_ctrl_pkg;
  localparam int REG_ID_W = 3;
  localparam int TMO_W    = 8;

  typedef logic [REG_ID_W-1:0] reg_id_t;

  typedef enum logic {
    RUN       = 1'b0,
    DATA_WAIT = 1'b1
  } state_e;

  localparam logic MEM_OWNER_FETCH = 1'b0;
  localparam logic MEM_OWNER_DATA  = 1'b1;
endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-facing signal bundle of the hazard controller: hazard inputs from
// IF/ID, ID/EX, EX and EX/MEM plus the pipeline-control outputs.
interface hazard_controller_if
  import cpu_ctrl_pkg::*;
#(
  parameter int STALL_CNT_W = 16
);
  reg_id_t                Rx_a_IFID;
  reg_id_t                Ry_a_IFID;
  logic                   useRx_a_IFID;
  logic                   useRy_a_IFID;
  logic                   memRead_a_IDEX;
  reg_id_t                registerToWriteId_a_IDEX;
  logic                   branchTaken_a_EX;
  logic                   memAccess_a_EXMEM;
  logic                   mem_ready;
  logic                   stallClear;
  logic                   pcWrite;
  logic                   ifidWrite;
  logic                   ifidFlush;
  logic                   idexFlush;
  logic                   pipeHold;
  logic                   memwbBubble;
  logic                   memOwner;
  logic                   memError;
  logic [STALL_CNT_W-1:0] stallCycles;

  modport master (
    output Rx_a_IFID, Ry_a_IFID, useRx_a_IFID, useRy_a_IFID, memRead_a_IDEX,
           registerToWriteId_a_IDEX, branchTaken_a_EX, memAccess_a_EXMEM,
           mem_ready, stallClear,
    input  pcWrite, ifidWrite, ifidFlush, idexFlush, pipeHold, memwbBubble,
           memOwner, memError, stallCycles
  );

  modport slave (
    input  Rx_a_IFID, Ry_a_IFID, useRx_a_IFID, useRy_a_IFID, memRead_a_IDEX,
           registerToWriteId_a_IDEX, branchTaken_a_EX, memAccess_a_EXMEM,
           mem_ready, stallClear,
    output pcWrite, ifidWrite, ifidFlush, idexFlush, pipeHold, memwbBubble,
           memOwner, memError, stallCycles
  );
endinterface

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clear beats increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                            cnt_d = '0;
    else if (inc_i && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: shared-RAM arbitration with timeout,
// taken-branch flush and load-use stall, plus a stall-cycle counter.
module hazard_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  hazard_controller_if.slave hc
);
  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic pc_w, ifid_w, ifid_f, idex_f, hold, bubble, owner, err;
  logic load_use, do_hold, do_rel;

  assign load_use = hc.memRead_a_IDEX &&
                    ((hc.useRx_a_IFID && (hc.Rx_a_IFID == hc.registerToWriteId_a_IDEX)) ||
                     (hc.useRy_a_IFID && (hc.Ry_a_IFID == hc.registerToWriteId_a_IDEX)));

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_f  = 1'b0;
    hold    = 1'b0;
    bubble  = 1'b0;
    owner   = MEM_OWNER_FETCH;
    err     = 1'b0;
    do_hold = 1'b0;
    do_rel  = 1'b0;

    case (state_q)
      RUN: begin
        if (hc.memAccess_a_EXMEM) begin
          if (hc.mem_ready) do_rel = 1'b1;
          else begin
            do_hold = 1'b1;
            state_d = DATA_WAIT;
            tmo_d   = TMO_W'(1);
          end
        end else if (hc.branchTaken_a_EX) begin
          // Load-use in the same cycle is on the wrong path and is dropped.
          ifid_f = 1'b1;
          idex_f = 1'b1;
        end else if (load_use) begin
          pc_w   = 1'b0;
          ifid_w = 1'b0;
          idex_f = 1'b1;
        end
      end
      DATA_WAIT: begin
        if (hc.mem_ready) do_rel = 1'b1;
        else if (tmo_q == TMO_W'(MEM_TIMEOUT)) begin
          do_rel = 1'b1;
          err    = 1'b1;
        end else begin
          do_hold = 1'b1;
          tmo_d   = tmo_q + TMO_W'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (do_hold) begin
      owner  = MEM_OWNER_DATA;
      pc_w   = 1'b0;
      ifid_w = 1'b0;
      hold   = 1'b1;
      bubble = 1'b1;
    end
    // The fetch slot was taken by data: refetch the same PC unless redirected.
    if (do_rel) begin
      owner   = MEM_OWNER_DATA;
      pc_w    = hc.branchTaken_a_EX;
      ifid_w  = 1'b1;
      ifid_f  = 1'b1;
      idex_f  = hc.branchTaken_a_EX;
      state_d = RUN;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
    end
  end

  assign hc.pcWrite     = rst & pc_w;
  assign hc.ifidWrite   = rst & ifid_w;
  assign hc.ifidFlush   = rst & ifid_f;
  assign hc.idexFlush   = rst & idex_f;
  assign hc.pipeHold    = rst & hold;
  assign hc.memwbBubble = rst & bubble;
  assign hc.memOwner    = rst & owner;
  assign hc.memError    = rst & err;

  logic [STALL_CNT_W-1:0] stall_cnt;

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (hc.stallClear),
    .inc_i (~pc_w),
    .cnt_o (stall_cnt)
  );

  assign hc.stallCycles = rst ? stall_cnt : '0;
endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage 16-bit CPU with 8 general registers.
- Detects load-use hazards, resolves taken-branch flushes, and arbitrates the single shared RAM port between instruction fetch (IF) and data access (MEM).
- Drives the PC and pipeline-register write, flush and hold controls.
- Complements the forwarding unit: it handles every hazard forwarding cannot cover.

Parameters:
MEM_TIMEOUT, 15, max cycles in DATA_WAIT before forced release (1..255)
STALL_CNT_W, 16, width of stall-cycle performance counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
Rx_a_IFID  in  3  first source register of instruction in ID
Ry_a_IFID  in  3  second source register of instruction in ID
useRx_a_IFID  in  1  ID instruction reads Rx
useRy_a_IFID  in  1  ID instruction reads Ry
memRead_a_IDEX  in  1  EX instruction is a load
registerToWriteId_a_IDEX  in  3  destination of EX instruction
branchTaken_a_EX  in  1  branch resolved taken in EX
memAccess_a_EXMEM  in  1  MEM instruction accesses shared RAM
mem_ready  in  1  RAM completes current data access this cycle
stallClear  in  1  synchronous clear of stallCycles
pcWrite  out  1  PC load enable
ifidWrite  out  1  IF/ID load enable
ifidFlush  out  1  load bubble into IF/ID (effective only with ifidWrite=1)
idexFlush  out  1  load bubble into ID/EX
pipeHold  out  1  hold ID/EX and EX/MEM
memwbBubble  out  1  load bubble into MEM/WB
memOwner  out  1  RAM port owner: 0=fetch, 1=data
memError  out  1  one-cycle pulse on timeout release
stallCycles  out  STALL_CNT_W  count of cycles with pcWrite=0

Behaviour:
- States: RUN, DATA_WAIT. Registered state and timeout counter (8 bit). Outputs are combinational from state and inputs.
- Reset (rst=0, asynchronous):
  - State goes to RUN; timeout counter and stallCycles go to 0.
  - While rst=0, all outputs are forced to 0.
- Default outputs in RUN: pcWrite=1, ifidWrite=1, all others 0.
- Priority: structural (data access) > branch > load-use.
- RUN with memAccess_a_EXMEM=1, mem_ready=0 (hold):
  - memOwner=1, pcWrite=0, ifidWrite=0, pipeHold=1, memwbBubble=1.
  - Next state DATA_WAIT; timeout counter := 1.
- Release outputs (RUN with memAccess_a_EXMEM=1 and mem_ready=1; or DATA_WAIT with mem_ready=1; or timeout):
  - memOwner=1, pipeHold=0, memwbBubble=0.
  - pcWrite=0, ifidWrite=1, ifidFlush=1 (the fetch slot was lost; refetch the same PC).
  - If branchTaken_a_EX=1 in the same cycle: pcWrite=1, ifidFlush=1, idexFlush=1.
  - Next state RUN.
- DATA_WAIT with mem_ready=0:
  - Hold outputs; counter increments.
  - When counter==MEM_TIMEOUT, release instead and pulse memError=1.
- Branch (RUN, no data access, branchTaken_a_EX=1): pcWrite=1, ifidFlush=1, idexFlush=1. Any simultaneous load-use is ignored because it is on the wrong path.
- Load-use (RUN, no data access, no branch):
  - Condition: memRead_a_IDEX=1 and ((useRx_a_IFID and Rx_a_IFID==registerToWriteId_a_IDEX) or (useRy_a_IFID and Ry_a_IFID==registerToWriteId_a_IDEX)).
  - Response: pcWrite=0, ifidWrite=0, idexFlush=1 for exactly one cycle. The next cycle re-evaluates with the bubble in EX.
- stallCycles:
  - Increments on each rising edge where pcWrite=0 and rst=1, saturating at all-ones.
  - stallClear=1 sets it to 0 and has priority over increment.
- memError is asserted only in the timeout-release cycle, never in the same cycle as a genuine mem_ready=1. If mem_ready=1 arrives at the timeout cycle, it is a normal release with memError=0.
- mem_ready in RUN without memAccess_a_EXMEM is ignored.

Decomposition:
- Shared package cpu_ctrl_pkg holds the state encoding (RUN=1'b0, DATA_WAIT=1'b1), the MEM_OWNER_FETCH/MEM_OWNER_DATA constants, and the register-id width (3).
- One natural sub-module: sat_counter (width-parameterised saturating counter with sync clear), instantiated for stallCycles.

Test Plan:
- Reset during DATA_WAIT (memAccess=1, mem_ready=0 held 3 cycles, then rst=0) -> all outputs 0 immediately; after rst=1, state is RUN with pcWrite=1, memOwner=0.
- Load-use: memRead_a_IDEX=1, registerToWriteId_a_IDEX=3, Rx_a_IFID=3, useRx=1 -> one cycle pcWrite=0, ifidWrite=0, idexFlush=1, stallCycles +1. Repeat with useRx=0 -> no stall.
- Branch+load-use in the same cycle -> pcWrite=1, ifidFlush=1, idexFlush=1, no stall, stallCycles unchanged.
- Data access, mem_ready after 4 cycles -> 4 hold cycles (pipeHold=1, memwbBubble=1, memOwner=1), then a release cycle with ifidFlush=1, pcWrite=0; stallCycles +5.
- Timeout, MEM_TIMEOUT=15, mem_ready never rises -> release in the 15th DATA_WAIT cycle with memError=1 for one cycle, then RUN.
- Saturation: STALL_CNT_W=4, force 20 stall cycles -> stallCycles=15; stallClear=1 -> 0 next edge.
